// File: rtl/parking_exit_gate.sv
// ---------------------------------------------------------------------------
// parking_exit_gate
//
// Exit-side controller for the car park. A car waiting on the inside of the
// exit barrier must present the exit token before the gate opens. Once the
// car has moved past the outer sensor and both sensors are clear, the car
// counts as gone and occupancy is decremented. This block also owns the
// occupancy count, which the entrance controller bumps with entry_pulse, and
// drives the two-digit occupancy display.
//
// Ports
//   clk           in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high reset
//   sensor_inner  in   1  car present on the inside of the exit barrier
//   sensor_outer  in   1  car present on the outside of the exit barrier
//   token         in   2  exit token from the keypad, 0 = nothing entered
//   entry_pulse   in   1  one-cycle pulse: a car has entered
//   GATE_OPEN     out  1  barrier open command
//   GREEN_LED     out  1  lit while the gate is open or the car is clearing
//   RED_LED       out  1  steady while waiting for a token, blinks in alarm
//   exit_pulse    out  1  one-cycle pulse: a car has left
//   full          out  1  occupancy has reached CAPACITY
//   occupancy     out  5  current car count
//   HEX_1         out  7  tens digit, active-low segments {g..a}
//   HEX_2         out  7  units digit, active-low segments {g..a}
// ---------------------------------------------------------------------------
module parking_exit_gate #(
    parameter int         CAPACITY    = 20,
    parameter logic [1:0] EXIT_CODE   = 2'b11,
    parameter int         TIMEOUT_CYC = 8,
    parameter int         BLINK_CYC   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_inner,
    input  logic       sensor_outer,
    input  logic [1:0] token,
    input  logic       entry_pulse,
    output logic       GATE_OPEN,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic       exit_pulse,
    output logic       full,
    output logic [4:0] occupancy,
    output logic [6:0] HEX_1,
    output logic [6:0] HEX_2
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam logic [4:0]    CAP        = 5'(CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TOKEN,
        S_OPEN,
        S_CLEARING,
        S_ALARM
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic [4:0]      occupancy_q, occupancy_d;
    logic            gate_open_q, gate_open_d;
    logic            green_q, green_d;
    logic            red_q, red_d;
    logic            exit_pulse_q, exit_pulse_d;
    logic            exit_dec;

    logic [4:0]      tens_digit;
    logic [4:0]      units_digit;

    // Active-low seven-segment encoding, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [4:0] d);
        logic [6:0] s;
        case (d)
            5'd0:    s = 7'b1000000;
            5'd1:    s = 7'b1111001;
            5'd2:    s = 7'b0100100;
            5'd3:    s = 7'b0110000;
            5'd4:    s = 7'b0011001;
            5'd5:    s = 7'b0010010;
            5'd6:    s = 7'b0000010;
            5'd7:    s = 7'b1111000;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0010000;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // Next-state logic. In WAIT_TOKEN a keyed token always wins over the
    // timeout and over the car backing away, so a driver who types the code
    // on the last cycle still gets through.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        exit_dec = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sensor_inner) begin
                    if (occupancy_q != 5'd0) begin
                        state_d = S_WAIT_TOKEN;
                        timer_d = '0;
                    end else begin
                        // A car at the exit while the park is empty is a phantom.
                        state_d = S_ALARM;
                    end
                end
            end
            S_WAIT_TOKEN: begin
                if (token == EXIT_CODE) begin
                    state_d = S_OPEN;
                end else if (token != 2'b00) begin
                    state_d = S_ALARM;
                end else if (!sensor_inner) begin
                    state_d = S_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_OPEN: begin
                if (sensor_outer) begin
                    state_d = S_CLEARING;
                end
            end
            S_CLEARING: begin
                if (!sensor_outer && !sensor_inner) begin
                    state_d  = S_IDLE;
                    exit_dec = 1'b1;
                end else if (sensor_outer && sensor_inner) begin
                    // A second car is following close behind the one leaving.
                    state_d = S_ALARM;
                end
            end
            S_ALARM: begin
                if (token == EXIT_CODE) begin
                    state_d = S_OPEN;
                end else if (!sensor_inner && !sensor_outer) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and blink logic are derived from the next state so the
    // registered outputs line up with the registered state: both change on
    // the same edge. The red LED is forced high on alarm entry, then toggles
    // every BLINK_CYC cycles while the alarm persists.
    always_comb begin
        gate_open_d  = (state_d == S_OPEN) || (state_d == S_CLEARING);
        green_d      = (state_d == S_OPEN) || (state_d == S_CLEARING);
        exit_pulse_d = exit_dec;
        red_d        = 1'b0;
        blink_d      = '0;
        if (state_d == S_WAIT_TOKEN) begin
            red_d = 1'b1;
        end else if (state_d == S_ALARM) begin
            if (state_q != S_ALARM) begin
                red_d   = 1'b1;
                blink_d = '0;
            end else if (blink_q == BLINK_LAST) begin
                red_d   = !red_q;
                blink_d = '0;
            end else begin
                red_d   = red_q;
                blink_d = blink_q + 1'b1;
            end
        end
    end

    // Occupancy update. An entry and an exit in the same cycle cancel out,
    // even when the park is full, so the entrance never loses a count to
    // saturation when a car is simultaneously leaving.
    always_comb begin
        occupancy_d = occupancy_q;
        if (entry_pulse && !exit_dec) begin
            if (occupancy_q < CAP) begin
                occupancy_d = occupancy_q + 5'd1;
            end
        end else if (exit_dec && !entry_pulse) begin
            if (occupancy_q != 5'd0) begin
                occupancy_d = occupancy_q - 5'd1;
            end
        end
    end

    // All state and registered outputs; reset aborts any exit in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            blink_q      <= '0;
            occupancy_q  <= 5'd0;
            gate_open_q  <= 1'b0;
            green_q      <= 1'b0;
            red_q        <= 1'b0;
            exit_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            blink_q      <= blink_d;
            occupancy_q  <= occupancy_d;
            gate_open_q  <= gate_open_d;
            green_q      <= green_d;
            red_q        <= red_d;
            exit_pulse_q <= exit_pulse_d;
        end
    end

    // Display and status decode straight from the occupancy register.
    always_comb begin
        tens_digit  = occupancy_q / 5'd10;
        units_digit = occupancy_q % 5'd10;
    end

    assign HEX_1      = seg7(tens_digit);
    assign HEX_2      = seg7(units_digit);
    assign full       = (occupancy_q == CAP);
    assign occupancy  = occupancy_q;
    assign GATE_OPEN  = gate_open_q;
    assign GREEN_LED  = green_q;
    assign RED_LED    = red_q;
    assign exit_pulse = exit_pulse_q;

endmodule

// File: tb/tb_parking_exit_gate.sv
// ---------------------------------------------------------------------------
// tb_parking_exit_gate
//
// Directed stimulus for the exit gate controller: reset state, a normal
// exit, the phantom-car alarm with its blink pattern, a wrong token followed
// by the right one, a tailgate, occupancy saturation with a coincident
// entry/exit, the token timeout, and reset asserted during clearing.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_parking_exit_gate;

    logic       clk;
    logic       reset;
    logic       sensor_inner;
    logic       sensor_outer;
    logic [1:0] token;
    logic       entry_pulse;
    logic       GATE_OPEN;
    logic       GREEN_LED;
    logic       RED_LED;
    logic       exit_pulse;
    logic       full;
    logic [4:0] occupancy;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;

    int checkCount = 0;
    int failCount  = 0;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG2 = 7'b0100100;
    localparam logic [6:0] SEG3 = 7'b0110000;
    localparam logic [6:0] SEG9 = 7'b0010000;

    parking_exit_gate dut (
        .clk          (clk),
        .reset        (reset),
        .sensor_inner (sensor_inner),
        .sensor_outer (sensor_outer),
        .token        (token),
        .entry_pulse  (entry_pulse),
        .GATE_OPEN    (GATE_OPEN),
        .GREEN_LED    (GREEN_LED),
        .RED_LED      (RED_LED),
        .exit_pulse   (exit_pulse),
        .full         (full),
        .occupancy    (occupancy),
        .HEX_1        (HEX_1),
        .HEX_2        (HEX_2)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic applyStimulus;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        repeat (3) applyStimulus();
        reset = 1'b0;
        applyStimulus();
    endtask

    task automatic pulseEntries(input int n);
        for (int i = 0; i < n; i++) begin
            entry_pulse = 1'b1;
            applyStimulus();
            entry_pulse = 1'b0;
            applyStimulus();
        end
    endtask

    initial begin
        reset        = 1'b1;
        sensor_inner = 1'b0;
        sensor_outer = 1'b0;
        token        = 2'b00;
        entry_pulse  = 1'b0;

        // Reset state.
        doReset();
        checkOutput("rst_occ",   occupancy,  0);
        checkOutput("rst_hex1",  HEX_1,      SEG0);
        checkOutput("rst_hex2",  HEX_2,      SEG0);
        checkOutput("rst_gate",  GATE_OPEN,  0);
        checkOutput("rst_green", GREEN_LED,  0);
        checkOutput("rst_red",   RED_LED,    0);
        checkOutput("rst_exit",  exit_pulse, 0);
        checkOutput("rst_full",  full,       0);

        // Normal exit: 3 cars in, one leaves.
        pulseEntries(3);
        checkOutput("n_occ3", occupancy, 3);
        checkOutput("n_hex2_3", HEX_2, SEG3);
        sensor_inner = 1'b1;
        applyStimulus();
        checkOutput("n_wait_red", RED_LED, 1);
        checkOutput("n_wait_gate", GATE_OPEN, 0);
        token = 2'b11;
        applyStimulus();
        checkOutput("n_open_gate", GATE_OPEN, 1);
        checkOutput("n_open_green", GREEN_LED, 1);
        checkOutput("n_open_red", RED_LED, 0);
        token = 2'b00;
        sensor_inner = 1'b0;
        sensor_outer = 1'b1;
        applyStimulus();
        checkOutput("n_clr_gate", GATE_OPEN, 1);
        checkOutput("n_clr_occ", occupancy, 3);
        sensor_outer = 1'b0;
        applyStimulus();
        checkOutput("n_exit_pulse", exit_pulse, 1);
        checkOutput("n_exit_occ", occupancy, 2);
        checkOutput("n_exit_hex2", HEX_2, SEG2);
        checkOutput("n_exit_gate", GATE_OPEN, 0);
        applyStimulus();
        checkOutput("n_pulse_once", exit_pulse, 0);
        checkOutput("n_occ_hold", occupancy, 2);

        // Phantom car with empty park: alarm, blink period 4.
        doReset();
        sensor_inner = 1'b1;
        applyStimulus();
        checkOutput("ph_red_entry", RED_LED, 1);
        checkOutput("ph_gate", GATE_OPEN, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("ph_red_hi", RED_LED, 1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("ph_red_lo", RED_LED, 0);
        end
        applyStimulus();
        checkOutput("ph_red_hi2", RED_LED, 1);
        sensor_inner = 1'b0;
        applyStimulus();
        checkOutput("ph_idle_red", RED_LED, 0);
        checkOutput("ph_occ", occupancy, 0);

        // Wrong token then right token, with 5 cars.
        pulseEntries(5);
        sensor_inner = 1'b1;
        applyStimulus();
        token = 2'b01;
        applyStimulus();
        checkOutput("wt_alarm_gate", GATE_OPEN, 0);
        checkOutput("wt_alarm_red", RED_LED, 1);
        token = 2'b11;
        applyStimulus();
        checkOutput("wt_open_gate", GATE_OPEN, 1);
        checkOutput("wt_open_red", RED_LED, 0);
        token = 2'b00;
        sensor_inner = 1'b0;
        sensor_outer = 1'b1;
        applyStimulus();
        sensor_outer = 1'b0;
        applyStimulus();
        checkOutput("wt_exit_pulse", exit_pulse, 1);
        checkOutput("wt_occ4", occupancy, 4);

        // Tailgate: both sensors high while clearing.
        sensor_inner = 1'b1;
        applyStimulus();
        token = 2'b11;
        applyStimulus();
        token = 2'b00;
        sensor_outer = 1'b1;
        applyStimulus();
        checkOutput("tg_clr_gate", GATE_OPEN, 1);
        applyStimulus();
        checkOutput("tg_alarm_gate", GATE_OPEN, 0);
        checkOutput("tg_alarm_red", RED_LED, 1);
        checkOutput("tg_no_pulse", exit_pulse, 0);
        sensor_inner = 1'b0;
        sensor_outer = 1'b0;
        applyStimulus();
        checkOutput("tg_occ4", occupancy, 4);
        checkOutput("tg_idle_red", RED_LED, 0);

        // Saturation at capacity.
        doReset();
        pulseEntries(19);
        checkOutput("sat_occ19", occupancy, 19);
        checkOutput("sat_full19", full, 0);
        checkOutput("sat_hex1_19", HEX_1, SEG1);
        checkOutput("sat_hex2_19", HEX_2, SEG9);
        pulseEntries(3);
        checkOutput("sat_occ20", occupancy, 20);
        checkOutput("sat_full", full, 1);
        checkOutput("sat_hex1", HEX_1, SEG2);
        checkOutput("sat_hex2", HEX_2, SEG0);

        // Exit coincident with entry while full: net unchanged.
        sensor_inner = 1'b1;
        applyStimulus();
        token = 2'b11;
        applyStimulus();
        token = 2'b00;
        sensor_inner = 1'b0;
        sensor_outer = 1'b1;
        applyStimulus();
        sensor_outer = 1'b0;
        entry_pulse = 1'b1;
        applyStimulus();
        entry_pulse = 1'b0;
        checkOutput("co_pulse", exit_pulse, 1);
        checkOutput("co_occ20", occupancy, 20);
        checkOutput("co_full", full, 1);

        // Plain exit from full.
        sensor_inner = 1'b1;
        applyStimulus();
        token = 2'b11;
        applyStimulus();
        token = 2'b00;
        sensor_inner = 1'b0;
        sensor_outer = 1'b1;
        applyStimulus();
        sensor_outer = 1'b0;
        applyStimulus();
        checkOutput("fx_occ19", occupancy, 19);
        checkOutput("fx_full", full, 0);

        // Token timeout: 8 cycles in WAIT_TOKEN with token 0.
        sensor_inner = 1'b1;
        applyStimulus();
        for (int i = 0; i < 7; i++) begin
            applyStimulus();
            checkOutput("to_wait_red", RED_LED, 1);
        end
        applyStimulus();
        sensor_inner = 1'b0;
        checkOutput("to_idle_red", RED_LED, 0);
        checkOutput("to_occ", occupancy, 19);
        checkOutput("to_no_pulse", exit_pulse, 0);

        // Reset asserted during clearing.
        sensor_inner = 1'b1;
        applyStimulus();
        token = 2'b11;
        applyStimulus();
        token = 2'b00;
        sensor_inner = 1'b0;
        sensor_outer = 1'b1;
        applyStimulus();
        checkOutput("rc_clr_gate", GATE_OPEN, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rc_gate", GATE_OPEN, 0);
        checkOutput("rc_green", GREEN_LED, 0);
        checkOutput("rc_occ", occupancy, 0);
        checkOutput("rc_hex2", HEX_2, SEG0);
        applyStimulus();
        reset = 1'b0;
        sensor_outer = 1'b0;
        applyStimulus();
        checkOutput("rc_no_pulse", exit_pulse, 0);
        checkOutput("rc_occ_after", occupancy, 0);
        checkOutput("rc_gate_after", GATE_OPEN, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
